pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the CPU datapath (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a data bundle with a valid/ready handshake, synchronous flush and an optional skid entry, so a downstream stall is absorbed without a combinational ready path. Control fields are zeroed on bubbles so downstream write-enables cannot fire spuriously. It also provides occupancy, stall-cycle and killed-beat counters for performance analysis.

Parameters:
CTRL_W, 8, width of control bundle (write enables, result select, FP load/store flags); forced to zero when no valid entry is presented.
DATA_W, 128, width of data bundle (ALU result, store data, instruction, PC+4, destination register); held when idle.
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all held entries and the incoming beat
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  DATA_W  upstream data bundle
out_valid  out  1  downstream beat valid
out_ready  in  1  downstream accepts beat
out_ctrl  out  CTRL_W  head control; all zero whenever out_valid=0
out_data  out  DATA_W  head data
occupancy  out  2  held entries, 0..2 (0..1 if SKID=0)
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
kill_cnt  out  CNT_W  valid entries discarded by flush, saturating
cnt_clr  in  1  synchronous clear of both counters

Behaviour:
- Reset, asynchronous: while asserted, all entries are invalid, out_valid=0, out_ctrl=0, out_data=0, occupancy=0, counters=0, and in_ready=0.
- After reset release: in_ready=1 from the first clock edge.
- Accept when in_valid&&in_ready. Emit when out_valid&&out_ready. Order is strict FIFO.
- Latency: an accepted beat appears on out_* on the next cycle if the head slot is empty or is emitted in the same cycle.
- SKID=1, head slot M and skid slot S:
  - in_ready = !S.valid, taken directly from a flop.
  - Accept with M empty, or with M emitting this cycle, loads M.
  - Accept with M full and not emitting loads S.
  - Emit with S valid moves S to M. A simultaneous accept then loads S.
- SKID=0:
  - in_ready = !M.valid || out_ready, combinational.
  - Simultaneous emit and accept replaces M with no bubble.
- Full (occupancy=2, in_ready=0): in_valid is ignored and the data is not sampled.
- Empty: out_ctrl=0 and out_valid=0. out_data keeps its last value.
- Flush has the highest priority. On the edge where flush=1:
  - all entries are invalidated and the incoming beat is dropped;
  - occupancy becomes 0;
  - kill_cnt += number of valid entries held before the edge (0..2); the incoming beat is not counted.
  - An emit handshake in the flush cycle still completes. That beat is not counted as killed.
- stall_cnt increments on each edge where out_valid&&!out_ready. It saturates at 2^CNT_W-1.
- kill_cnt saturates at 2^CNT_W-1.
- cnt_clr has priority over increments in the same cycle. It does not affect data entries.
- Reset mid-operation: everything returns to the reset state immediately; no partial state survives.
- No X propagation: unused slot contents do not reach out_ctrl.

Decomposition:
- Shared package pipe_pkg: default widths; an occupancy enum (EMPTY=0, ONE=1, TWO=2); the saturating-increment function.
- Sub-module pipe_slot: one entry with valid, ctrl, data, load enable, clear, and asynchronous reset. It is instantiated once or twice depending on SKID.
- The counter logic stays in pipe_stage_reg.

Test Plan:
- Streaming, SKID=1, out_ready=1: in_valid=1 with in_data=0x1..0xA on 10 cycles -> out_data 0x1..0xA on cycles 2..11, occupancy never >1, stall_cnt=0.
- Backpressure, SKID=1: out_ready=0 for 3 cycles while 0xA1,0xA2,0xA3 are offered -> occupancy 1 then 2, in_ready=0 on cycle 3, 0xA3 not accepted, stall_cnt=3; after release out_data=0xA1 then 0xA2.
- Flush with two held entries plus an incoming beat -> next cycle occupancy=0, out_valid=0, out_ctrl=0, kill_cnt=2; the incoming beat never appears.
- SKID=0 stall: out_ready=0 with M full -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> M replaced with no bubble.
- Counter saturation with CNT_W=4: 20 stall cycles -> stall_cnt=15; cnt_clr together with a stall cycle -> 0.
- Asynchronous reset asserted between clock edges with occupancy=2 -> out_valid=0, out_ctrl=0, occupancy=0 immediately; in_ready=1 on the first edge after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths, occupancy encoding and counter helpers for the pipeline stage register.
package pipe_pkg;

  localparam int unsigned CTRL_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 128;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // Counters are carried in 32 bits here, so instances are limited to CNT_W <= 32.
  function automatic logic [31:0] sat_add(input logic [31:0] cur,
                                          input logic [1:0]  inc,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, cur} + {31'd0, inc};
    if (sum > {1'b0, max_val}) return max_val;
    return sum[31:0];
  endfunction

  function automatic occ_e occ_of(input logic m_v, input logic s_v);
    occ_e occ;
    case ({m_v, s_v})
      2'b11:        occ = TWO;
      2'b10, 2'b01: occ = ONE;
      default:      occ = EMPTY;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag plus control/data payload. Clear beats load,
// clearing zeroes the control bundle but leaves data untouched.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clr,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = ld_ctrl;
      data_d  = ld_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush, optional
// skid entry and saturating stall/kill performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  kill_cnt,
  input  logic              cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, m_ld_ctrl;
  logic [DATA_W-1:0] m_data, m_ld_data;
  logic              m_load, m_clr;
  logic              accept, emit;
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  kill_cnt_q, kill_cnt_d;
  logic [1:0]        kill_inc;
  occ_e              occ;

  assign accept = in_valid && in_ready;
  assign emit   = m_valid && out_ready;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (m_load),
    .clr     (m_clr),
    .ld_ctrl (m_ld_ctrl),
    .ld_data (m_ld_data),
    .valid   (m_valid),
    .ctrl    (m_ctrl),
    .data    (m_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic              s_load, s_clr, m_from_s;
      logic [CTRL_W-1:0] s_ctrl;
      logic [DATA_W-1:0] s_data;

      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (s_load),
        .clr     (s_clr),
        .ld_ctrl (in_ctrl),
        .ld_data (in_data),
        .valid   (s_valid),
        .ctrl    (s_ctrl),
        .data    (s_data)
      );

      // The skid entry is always the older beat, so it refills the head first.
      assign m_from_s  = emit && s_valid;
      assign m_load    = m_from_s || (accept && (!m_valid || emit));
      assign m_clr     = flush || (emit && !m_load);
      assign m_ld_ctrl = m_from_s ? s_ctrl : in_ctrl;
      assign m_ld_data = m_from_s ? s_data : in_data;
      assign s_load    = accept && m_valid && (!emit || s_valid);
      assign s_clr     = flush || (m_from_s && !s_load);
      assign rdy_d     = !(!s_clr && (s_load || s_valid));
      assign in_ready  = rdy_q;
    end else begin : g_single
      assign s_valid   = 1'b0;
      assign m_load    = accept;
      assign m_clr     = flush || (emit && !accept);
      assign m_ld_ctrl = in_ctrl;
      assign m_ld_data = in_data;
      assign rdy_d     = 1'b1;
      assign in_ready  = rdy_q && (!m_valid || out_ready);
    end
  endgenerate

  // A beat leaving on the flush edge is delivered, so it is not counted as killed.
  always_comb begin
    kill_inc = 2'd0;
    if (flush) kill_inc = {1'b0, m_valid && !emit} + {1'b0, s_valid};
    stall_cnt_d = CNT_W'(sat_add(32'(stall_cnt_q), {1'b0, m_valid && !out_ready}, 32'(CNT_MAX)));
    kill_cnt_d  = CNT_W'(sat_add(32'(kill_cnt_q), kill_inc, 32'(CNT_MAX)));
    if (cnt_clr) begin
      stall_cnt_d = '0;
      kill_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q       <= 1'b0;
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      rdy_q       <= rdy_d;
      stall_cnt_q <= stall_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign occ       = occ_of(m_valid, s_valid);
  assign occupancy = occ;
  assign out_valid = m_valid;
  assign out_ctrl  = m_valid ? m_ctrl : '0;
  assign out_data  = m_data;
  assign stall_cnt = stall_cnt_q;
  assign kill_cnt  = kill_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance and a single-entry instance share stimulus
// and are both tracked by a FIFO-level reference model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready, cnt_clr;
  logic [7:0]  in_ctrl;
  logic [31:0] in_data;

  logic        ir_a, ov_a, ir_b, ov_b;
  logic [7:0]  octrl_a, octrl_b;
  logic [31:0] odata_a, odata_b;
  logic [1:0]  occ_a, occ_b;
  logic [3:0]  stall_a, stall_b, kill_a, kill_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .SKID(1), .CNT_W(4)) u_dut_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_a), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov_a), .out_ready(out_ready), .out_ctrl(octrl_a), .out_data(odata_a),
    .occupancy(occ_a), .stall_cnt(stall_a), .kill_cnt(kill_a), .cnt_clr(cnt_clr)
  );

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .SKID(0), .CNT_W(4)) u_dut_single (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_b), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov_b), .out_ready(out_ready), .out_ctrl(octrl_b), .out_data(odata_b),
    .occupancy(occ_b), .stall_cnt(stall_b), .kill_cnt(kill_b), .cnt_clr(cnt_clr)
  );

  // Reference model: per instance a FIFO of {ctrl,data} with capacity 2 (skid) or 1.
  int          mcnt [2];
  logic [39:0] ment [2][2];
  logic [31:0] mlast [2];
  int          mst [2];
  int          mkl [2];
  bit          started;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; mlast[k] = '0; mst[k] = 0; mkl[k] = 0;
      ment[k][0] = '0; ment[k][1] = '0;
    end
    started = 1'b0;
  endtask

  function automatic bit model_ready(input int k);
    if (!started) return 1'b0;
    if (k == 0) return mcnt[k] < 2;
    return (mcnt[k] == 0) || out_ready;
  endfunction

  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      logic        a_ir, a_ov;
      logic [7:0]  a_ctrl, e_ctrl;
      logic [31:0] a_data;
      logic [1:0]  a_occ;
      logic [3:0]  a_st, a_kl;
      string       p;
      if (k == 0) begin
        a_ir = ir_a; a_ov = ov_a; a_ctrl = octrl_a; a_data = odata_a;
        a_occ = occ_a; a_st = stall_a; a_kl = kill_a; p = "skid";
      end else begin
        a_ir = ir_b; a_ov = ov_b; a_ctrl = octrl_b; a_data = odata_b;
        a_occ = occ_b; a_st = stall_b; a_kl = kill_b; p = "single";
      end
      e_ctrl = (mcnt[k] > 0) ? ment[k][0][39:32] : 8'h00;
      chk({p, "_in_ready"},  32'(a_ir),   32'(model_ready(k)));
      chk({p, "_out_valid"}, 32'(a_ov),   32'(mcnt[k] > 0));
      chk({p, "_out_ctrl"},  32'(a_ctrl), 32'(e_ctrl));
      chk({p, "_out_data"},  a_data,      mlast[k]);
      chk({p, "_occupancy"}, 32'(a_occ),  32'(mcnt[k]));
      chk({p, "_stall_cnt"}, 32'(a_st),   32'(mst[k]));
      chk({p, "_kill_cnt"},  32'(a_kl),   32'(mkl[k]));
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      bit acc, emt, stl;
      int kil;
      acc = in_valid && model_ready(k);
      emt = (mcnt[k] > 0) && out_ready;
      stl = (mcnt[k] > 0) && !out_ready;
      kil = flush ? (mcnt[k] - (emt ? 1 : 0)) : 0;
      if (cnt_clr) begin
        mst[k] = 0;
        mkl[k] = 0;
      end else begin
        mst[k] = (mst[k] + int'(stl) > 15) ? 15 : mst[k] + int'(stl);
        mkl[k] = (mkl[k] + kil > 15) ? 15 : mkl[k] + kil;
      end
      if (emt) begin
        ment[k][0] = ment[k][1];
        mcnt[k]--;
      end
      if (flush) mcnt[k] = 0;
      else if (acc) begin
        ment[k][mcnt[k]] = {in_ctrl, in_data};
        mcnt[k]++;
      end
      if (mcnt[k] > 0) mlast[k] = ment[k][0][31:0];
    end
    started = 1'b1;
  endtask

  task automatic apply(input bit iv, input logic [7:0] ic, input logic [31:0] id,
                       input bit ordy, input bit fl, input bit cc);
    in_valid = iv; in_ctrl = ic; in_data = id;
    out_ready = ordy; flush = fl; cnt_clr = cc;
    #1;
  endtask

  task automatic tick();
    model_check();
    $display("cyc %0d: in_v=%0b ctrl=%02h data=%08h out_rdy=%0b flush=%0b clr=%0b | skid occ=%0d v=%0b out=%08h | single occ=%0d v=%0b out=%08h",
             cyc, in_valid, in_ctrl, in_data, out_ready, flush, cnt_clr,
             occ_a, ov_a, odata_a, occ_b, ov_b, odata_b);
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reset is raised between edges and checked immediately, then released between edges.
  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    in_ctrl = '0; in_data = '0;
    reset = 1'b1;
    #1;
    model_reset();
    model_check();
    chk("rst_out_valid", 32'(ov_a), 32'd0);
    chk("rst_out_ctrl",  32'(octrl_a), 32'd0);
    chk("rst_occupancy", 32'(occ_a), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rel_in_ready_skid",   32'(ir_a), 32'd0);
    chk("rel_in_ready_single", 32'(ir_b), 32'd0);
  endtask

  typedef struct {
    bit          iv;
    logic [7:0]  ic;
    logic [31:0] id;
    bit          ordy;
    bit          fl;
    bit          cc;
    bit          e_ov;
    logic [7:0]  e_ctrl;
    logic [31:0] e_data;
    logic [1:0]  e_occ;
    bit          e_ir;
    logic [3:0]  e_st;
    logic [3:0]  e_kl;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // Backpressure, flush with two held entries, flush during an emit, counter clear.
    tbl[0]  = '{1, 8'hC1, 32'hA1, 0, 0, 0,  0, 8'h00, 32'h00, 2'd0, 1, 4'd0, 4'd0};
    tbl[1]  = '{1, 8'hC2, 32'hA2, 0, 0, 0,  1, 8'hC1, 32'hA1, 2'd1, 1, 4'd0, 4'd0};
    tbl[2]  = '{1, 8'hC3, 32'hA3, 0, 0, 0,  1, 8'hC1, 32'hA1, 2'd2, 0, 4'd1, 4'd0};
    tbl[3]  = '{1, 8'hC3, 32'hA3, 0, 0, 0,  1, 8'hC1, 32'hA1, 2'd2, 0, 4'd2, 4'd0};
    tbl[4]  = '{0, 8'h00, 32'h00, 1, 0, 0,  1, 8'hC1, 32'hA1, 2'd2, 0, 4'd3, 4'd0};
    tbl[5]  = '{0, 8'h00, 32'h00, 1, 0, 0,  1, 8'hC2, 32'hA2, 2'd1, 1, 4'd3, 4'd0};
    tbl[6]  = '{0, 8'h00, 32'h00, 0, 0, 0,  0, 8'h00, 32'hA2, 2'd0, 1, 4'd3, 4'd0};
    tbl[7]  = '{1, 8'hB1, 32'hB1, 0, 0, 0,  0, 8'h00, 32'hA2, 2'd0, 1, 4'd3, 4'd0};
    tbl[8]  = '{1, 8'hB2, 32'hB2, 0, 0, 0,  1, 8'hB1, 32'hB1, 2'd1, 1, 4'd3, 4'd0};
    tbl[9]  = '{1, 8'hB3, 32'hB3, 0, 1, 0,  1, 8'hB1, 32'hB1, 2'd2, 0, 4'd4, 4'd0};
    tbl[10] = '{0, 8'h00, 32'h00, 1, 0, 0,  0, 8'h00, 32'hB1, 2'd0, 1, 4'd5, 4'd2};
    tbl[11] = '{1, 8'hD1, 32'hD1, 1, 0, 0,  0, 8'h00, 32'hB1, 2'd0, 1, 4'd5, 4'd2};
    tbl[12] = '{1, 8'hD2, 32'hD2, 1, 1, 0,  1, 8'hD1, 32'hD1, 2'd1, 1, 4'd5, 4'd2};
    tbl[13] = '{0, 8'h00, 32'h00, 1, 0, 1,  0, 8'h00, 32'hD1, 2'd0, 1, 4'd5, 4'd2};
    tbl[14] = '{0, 8'h00, 32'h00, 0, 0, 0,  0, 8'h00, 32'hD1, 2'd0, 1, 4'd0, 4'd0};

    reset = 1'b1;
    do_reset();
    apply(0, 8'h00, 32'h0, 0, 0, 0);
    tick();

    for (int r = 0; r < 15; r++) begin
      apply(tbl[r].iv, tbl[r].ic, tbl[r].id, tbl[r].ordy, tbl[r].fl, tbl[r].cc);
      chk($sformatf("tbl%0d_out_valid", r), 32'(ov_a),    32'(tbl[r].e_ov));
      chk($sformatf("tbl%0d_out_ctrl", r),  32'(octrl_a), 32'(tbl[r].e_ctrl));
      chk($sformatf("tbl%0d_out_data", r),  odata_a,      tbl[r].e_data);
      chk($sformatf("tbl%0d_occupancy", r), 32'(occ_a),   32'(tbl[r].e_occ));
      chk($sformatf("tbl%0d_in_ready", r),  32'(ir_a),    32'(tbl[r].e_ir));
      chk($sformatf("tbl%0d_stall_cnt", r), 32'(stall_a), 32'(tbl[r].e_st));
      chk($sformatf("tbl%0d_kill_cnt", r),  32'(kill_a),  32'(tbl[r].e_kl));
      tick();
    end

    // Streaming with out_ready held high: one-cycle latency, no stalls.
    do_reset();
    apply(0, 8'h00, 32'h0, 1, 0, 0);
    tick();
    for (int i = 0; i <= 10; i++) begin
      apply(i < 10, 8'(i), 32'(i + 1), 1, 0, 0);
      if (i >= 1) begin
        chk("stream_out_valid", 32'(ov_a), 32'd1);
        chk("stream_out_data", odata_a, 32'(i));
      end
      chk("stream_occ_le1", 32'(occ_a > 2'd1), 32'd0);
      tick();
    end
    chk("stream_stall_cnt", 32'(stall_a), 32'd0);

    // Single-entry variant: combinational in_ready and bubble-free replacement.
    do_reset();
    apply(0, 8'h00, 32'h0, 0, 0, 0);
    tick();
    apply(1, 8'hE1, 32'hE1, 0, 0, 0);
    tick();
    apply(1, 8'hE2, 32'hE2, 0, 0, 0);
    chk("single_full_in_ready", 32'(ir_b), 32'd0);
    tick();
    apply(1, 8'hE3, 32'hE3, 1, 0, 0);
    chk("single_release_in_ready", 32'(ir_b), 32'd1);
    chk("single_head_e1", odata_b, 32'hE1);
    tick();
    apply(0, 8'h00, 32'h0, 1, 0, 0);
    chk("single_no_bubble_valid", 32'(ov_b), 32'd1);
    chk("single_no_bubble_data", odata_b, 32'hE3);
    tick();

    // Stall counter saturation and clear-over-increment.
    do_reset();
    apply(0, 8'h00, 32'h0, 0, 0, 0);
    tick();
    apply(1, 8'hF1, 32'hF1, 0, 0, 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      apply(0, 8'h00, 32'h0, 0, 0, 0);
      tick();
    end
    apply(0, 8'h00, 32'h0, 0, 0, 0);
    chk("sat_stall_skid", 32'(stall_a), 32'd15);
    chk("sat_stall_single", 32'(stall_b), 32'd15);
    tick();
    apply(0, 8'h00, 32'h0, 0, 0, 1);
    tick();
    apply(0, 8'h00, 32'h0, 0, 0, 0);
    chk("clr_stall_skid", 32'(stall_a), 32'd0);
    chk("clr_stall_single", 32'(stall_b), 32'd0);
    tick();

    // Asynchronous reset with both skid entries held.
    do_reset();
    apply(0, 8'h00, 32'h0, 0, 0, 0);
    tick();
    apply(1, 8'h71, 32'h71, 0, 0, 0);
    tick();
    apply(1, 8'h72, 32'h72, 0, 0, 0);
    tick();
    apply(0, 8'h00, 32'h0, 0, 0, 0);
    chk("pre_rst_occupancy", 32'(occ_a), 32'd2);
    do_reset();
    apply(0, 8'h00, 32'h0, 0, 0, 0);
    tick();
    apply(0, 8'h00, 32'h0, 0, 0, 0);
    chk("post_rst_in_ready", 32'(ir_a), 32'd1);
    tick();

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 99) < 70, 8'($urandom), $urandom,
            $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 6,
            $urandom_range(0, 99) < 3);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
